// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, visible window, delayed syncs.
// Defaults give 800x600@72Hz from a 50 MHz pixel clock.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 800,
    parameter int H_FP       = 56,
    parameter int H_SYNC     = 120,
    parameter int H_BP       = 64,
    parameter int V_VISIBLE  = 600,
    parameter int V_FP       = 37,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 23,
    parameter int H_POL      = 1,
    parameter int V_POL      = 1,
    parameter int SYNC_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        display_on,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // One extra bit on the decode bounds so a sync window ending exactly
    // at the largest legal total cannot wrap to zero.
    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS_END = 12'(H_VISIBLE);
    localparam logic [11:0] H_SYN_BEG = 12'(H_VISIBLE + H_FP);
    localparam logic [11:0] H_SYN_END = 12'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYN_BEG = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_SYN_END = 11'(V_VISIBLE + V_FP + V_SYNC);

    // Inactive pin levels; active level is the complement.
    localparam logic HS_OFF = (H_POL != 0) ? 1'b0 : 1'b1;
    localparam logic VS_OFF = (V_POL != 0) ? 1'b0 : 1'b1;

    if (H_TOTAL > 2048) begin : g_h_total_err
        $error("vga_timing_gen: H_TOTAL exceeds 2048");
    end
    if (V_TOTAL > 1024) begin : g_v_total_err
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 3) begin : g_delay_err
        $error("vga_timing_gen: SYNC_DELAY must be 0..3");
    end

    logic        h_wrap;
    logic        v_wrap;
    logic [10:0] h_nxt;
    logic [9:0]  v_nxt;
    logic        disp_nxt;
    logic        hs_nxt;
    logic        vs_nxt;
    logic        hs_raw;
    logic        vs_raw;

    // Next counter values and the decodes taken from them, so registered
    // decodes line up with the registered counters.
    always_comb begin
        h_wrap   = (hcount == H_LAST);
        v_wrap   = (vcount == V_LAST);
        h_nxt    = hcount;
        v_nxt    = vcount;
        disp_nxt = 1'b0;
        hs_nxt   = HS_OFF;
        vs_nxt   = VS_OFF;
        if (h_wrap) begin
            h_nxt = '0;
            v_nxt = v_wrap ? '0 : vcount + 10'd1;
        end else begin
            h_nxt = hcount + 11'd1;
        end
        disp_nxt = ({1'b0, h_nxt} < H_VIS_END) &&
                   ({1'b0, v_nxt} < V_VIS_END);
        if (({1'b0, h_nxt} >= H_SYN_BEG) &&
            ({1'b0, h_nxt} <  H_SYN_END)) begin
            hs_nxt = ~HS_OFF;
        end
        if (({1'b0, v_nxt} >= V_SYN_BEG) &&
            ({1'b0, v_nxt} <  V_SYN_END)) begin
            vs_nxt = ~VS_OFF;
        end
    end

    // Counters, visible window, undelayed syncs and strobes; all hold
    // (strobes clear) while pix_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            display_on  <= 1'b0;
            hs_raw      <= HS_OFF;
            vs_raw      <= VS_OFF;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            display_on  <= disp_nxt;
            hs_raw      <= hs_nxt;
            vs_raw      <= vs_nxt;
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

    if (SYNC_DELAY == 0) begin : g_no_delay
        assign hsync = hs_raw;
        assign vsync = vs_raw;
    end else begin : g_delay
        logic [SYNC_DELAY-1:0] hs_dly;
        logic [SYNC_DELAY-1:0] vs_dly;

        // Sync shift register, clocked every clk regardless of pix_en.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hs_dly <= {SYNC_DELAY{HS_OFF}};
                vs_dly <= {SYNC_DELAY{VS_OFF}};
            end else begin
                hs_dly[0] <= hs_raw;
                vs_dly[0] <= vs_raw;
                for (int i = 1; i < SYNC_DELAY; i++) begin
                    hs_dly[i] <= hs_dly[i-1];
                    vs_dly[i] <= vs_dly[i-1];
                end
            end
        end

        assign hsync = hs_dly[SYNC_DELAY-1];
        assign vsync = vs_dly[SYNC_DELAY-1];
    end

endmodule
